uart_tx_reporter: RTL and testbench
===================================

# uart_tx_reporter

Buffered 8N1 UART transmitter that returns status and acknowledgement bytes from the FPGA to the host over the RS232 link. It runs on the same 115200 Hz bit clock as the receive path, so each clock period is exactly one bit time. A small FIFO decouples byte producers (SNR/GPIO control logic) from the serial line. Frames are sent back-to-back while data is queued.

## Interface
- DEPTH, 8, FIFO depth in bytes; power of two, 2..64
- STOP_BITS, 1, number of stop bits per frame; 1 or 2
- clk  in  1  115200 Hz bit clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  push wr_data into FIFO this edge
- wr_data  in  8  byte to queue
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- level  out  $clog2(DEPTH)+1  bytes currently queued, not counting the frame on the line
- overflow  out  1  sticky; set when a write is dropped, cleared only by reset
- busy  out  1  frame in progress, start bit through last stop bit
- Tx  out  1  serial output, idle high, registered

## Operation
- Reset values: Tx=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE. FIFO pointers are cleared and queued bytes are discarded.
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. level is an explicit counter.
- Write acceptance: a write is accepted iff wr_en=1 and full=0, evaluated before the edge. A write while full is dropped, leaves FIFO contents unchanged, and sets overflow.
- Pop: occurs only when the FSM loads a byte, and only when empty=0.
- Simultaneous push and pop on one edge: both take effect and level is unchanged.
- A write into an empty FIFO cannot be popped on the same edge. The byte becomes visible one edge later.
- FSM states:
  - IDLE: Tx=1. If empty=0, pop into shift register, Tx<=0, go to DATA.
  - DATA: Tx<=shift[0] and shift right. After 8 bits, Tx<=1 and go to STOP.
  - STOP: hold Tx=1 for STOP_BITS cycles total. At the end, if empty=0, pop, Tx<=0 and stay framing (no idle gap); else go to IDLE.
- Bit order: LSB first. Frame = 1 start (0), 8 data, STOP_BITS stop (1).
- busy=1 from the edge that drives the start bit until the edge that ends the last stop bit.
- Reset mid-frame: Tx=1 on the next edge, the frame is truncated, and the FIFO is flushed. No partial frame resumes.
- Unused state encodings: go to IDLE with Tx=1.

## Timing
- Every Tx level is held exactly one clk period.
- Latency with empty FIFO in IDLE: write on edge E0; start bit driven at E1; data bit0..bit7 at E2..E9; stop at E10 (and E11 when STOP_BITS=2); back to IDLE or next start at E10+STOP_BITS.
- Frame period: 9+STOP_BITS cycles. Back-to-back frames have zero idle cycles.
- full, empty, level and overflow update on the same edge as the push/pop that causes them.

## Test plan
- Single byte: write 0x55 at E0 -> Tx = 0 at E1, then 1,0,1,0,1,0,1,0 at E2..E9, then 1 at E10. busy=1 over E1..E10, then busy=0, empty=1.
- Back-to-back: write 0xA3 then 0x0F on consecutive edges -> 20 contiguous bit cycles: 0,1,1,0,0,0,1,0,1,1 followed by 0,1,1,1,1,0,0,0,0,1. No idle cycle between frames.
- Overflow (DEPTH=8): write 0x00..0x09 on E0..E9 -> full=1 after E8; 0x09 dropped; overflow=1 from E9 and stays set; exactly bytes 0x00..0x08 are transmitted in order.
- STOP_BITS=2: write 0xFF, 0x00 -> each frame is 11 cycles; Tx high for 2 cycles between the last data bit and the next start bit.
- Reset mid-frame: queue 3 bytes, assert reset during data bit3 of the first frame -> Tx=1, busy=0, level=0, empty=1 on the next edge; no further frames without new writes.
- Pointer wrap: write and transmit 20 single bytes 0x10..0x23 with gaps -> all are sent correctly across pointer wrap-around; level never exceeds 1.

Source files
------------

// File: rtl/uart_tx_reporter.sv
// rtl/uart_tx_reporter.sv - buffered 8N1 UART transmitter with byte FIFO
// One clk period is one bit time; frames go out back-to-back while bytes are queued.
module uart_tx_reporter #(
  parameter int DEPTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     Tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [1:0]  STOP_L   = 2'(STOP_BITS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    stop_cnt_q, stop_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          push, pop;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign Tx       = tx_q;
  assign push     = wr_en && !full;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        pop    = !empty;
      end
      ST_DATA: begin
        if (bit_cnt_q != 4'd8) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          tx_d       = 1'b1;
          state_d    = ST_STOP;
          stop_cnt_d = 2'd1;
        end
      end
      ST_STOP: begin
        if (stop_cnt_q != STOP_L) begin
          tx_d       = 1'b1;
          stop_cnt_d = stop_cnt_q + 2'd1;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Loading a byte always emits the start bit, from IDLE or straight out of STOP.
    if (pop) begin
      shift_d   = fifo_mem[rd_ptr_q];
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      state_d   = ST_DATA;
      bit_cnt_d = 4'd0;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q | (wr_en & full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 2'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: clearing the pointers and level discards queued bytes.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_reporter.sv
// tb/tb_uart_tx_reporter.sv - self-checking bench for uart_tx_reporter
// Two instances (1 and 2 stop bits) share stimulus; each is compared to a bit-stream model.
module tb_uart_tx_reporter;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;

  logic       full_o [2];
  logic       empty_o [2];
  logic       ovf_o [2];
  logic       busy_o [2];
  logic       tx_o [2];
  logic [3:0] level_o [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq [2][$];
  logic [11:0] m_frame [2];
  int          m_left [2];
  logic        m_tx [2];
  logic        m_busy [2];
  logic        m_ovf [2];

  uart_tx_reporter #(.DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[0]), .empty(empty_o[0]), .level(level_o[0]),
    .overflow(ovf_o[0]), .busy(busy_o[0]), .Tx(tx_o[0])
  );

  uart_tx_reporter #(.DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[1]), .empty(empty_o[1]), .level(level_o[1]),
    .overflow(ovf_o[1]), .busy(busy_o[1]), .Tx(tx_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line model: a queued byte becomes a list of frame bits that is shifted out one per edge.
  task automatic model_edge(input int k, input int sb, input logic rst,
                            input logic we, input logic [7:0] d);
    logic was_full;
    logic [7:0] b;
    if (rst) begin
      mq[k].delete();
      m_left[k] = 0;
      m_tx[k]   = 1'b1;
      m_busy[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      return;
    end
    was_full = (mq[k].size() >= DEPTH);
    if (m_left[k] == 0 && mq[k].size() > 0) begin
      b = mq[k].pop_front();
      m_frame[k] = {3'b111, b, 1'b0};
      m_left[k] = 9 + sb;
    end
    if (m_left[k] > 0) begin
      m_tx[k]    = m_frame[k][0];
      m_frame[k] = m_frame[k] >> 1;
      m_left[k]  = m_left[k] - 1;
      m_busy[k]  = 1'b1;
    end else begin
      m_tx[k]   = 1'b1;
      m_busy[k] = 1'b0;
    end
    if (we && !was_full) mq[k].push_back(d);
    else if (we) m_ovf[k] = 1'b1;
  endtask

  task automatic tick(input logic rst, input logic we, input logic [7:0] d);
    reset   = rst;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, k + 1, rst, we, d);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tx%0d", k),    32'(tx_o[k]),    32'(m_tx[k]));
      chk($sformatf("busy%0d", k),  32'(busy_o[k]),  32'(m_busy[k]));
      chk($sformatf("level%0d", k), 32'(level_o[k]), 32'(mq[k].size()));
      chk($sformatf("empty%0d", k), 32'(empty_o[k]), 32'(mq[k].size() == 0));
      chk($sformatf("full%0d", k),  32'(full_o[k]),  32'(mq[k].size() == DEPTH));
      chk($sformatf("ovf%0d", k),   32'(ovf_o[k]),   32'(m_ovf[k]));
    end
    reset = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    logic [9:0] cap;
    int r;

    repeat (3) tick(1'b1, 1'b0, 8'h00);
    chk("reset_tx", 32'(tx_o[0]), 32'd1);
    chk("reset_empty", 32'(empty_o[0]), 32'd1);

    // Single byte 0x55, start bit through stop bit captured on dut1.
    tick(1'b0, 1'b1, 8'h55);
    cap = '0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (i < 10) cap[i] = tx_o[0];
    end
    chk("frame_55", 32'(cap), 32'h2AA);
    chk("idle_after_55", 32'(busy_o[0]), 32'd0);

    tick(1'b0, 1'b1, 8'hA3);
    tick(1'b0, 1'b1, 8'h0F);
    repeat (25) tick(1'b0, 1'b0, 8'h00);

    tick(1'b0, 1'b1, 8'hFF);
    tick(1'b0, 1'b1, 8'h00);
    repeat (25) tick(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 8'(i));
    chk("ovf_set", 32'(ovf_o[0]), 32'd1);
    repeat (110) tick(1'b0, 1'b0, 8'h00);
    chk("ovf_sticky", 32'(ovf_o[0]), 32'd1);

    // Reset during data bit 3 of the first of three queued frames.
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'hC0 + 8'(i));
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("rst_mid_tx", 32'(tx_o[0]), 32'd1);
    chk("rst_mid_level", 32'(level_o[0]), 32'd0);
    repeat (15) tick(1'b0, 1'b0, 8'h00);
    chk("rst_mid_quiet", 32'(busy_o[0]), 32'd0);

    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 8'h10 + 8'(i));
      chk("wrap_level_le1", 32'(level_o[0] <= 4'd1), 32'd1);
      repeat (13) tick(1'b0, 1'b0, 8'h00);
    end

    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 199));
      tick(r == 0, r < 70, 8'($urandom));
    end
    repeat (120) tick(1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
